// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution result streamer.
// Holds the pixel width, the streamer FSM encoding and the 8-bit saturating requantiser.
package conv_pkg;

    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Unsigned clamp of a 16-bit result pixel into 8 bits for display.
    function automatic logic [7:0] sat8(input logic [15:0] pix);
        return (pix > 16'd255) ? 8'hFF : pix[7:0];
    endfunction

endpackage

// File: rtl/conv_rise_detect.sv
// Rising-edge detector for the conv core's done level.
// done_q is registered every cycle; o_rise is combinational from the live level.
module conv_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/conv_result_streamer.sv
// Snapshots the conv core's flat result on a done rise and streams it row-major over valid/ready.
// Optional macro CONV_STREAM_SAT8_EN: output pixels are saturated to 8 bits, zero-extended.
module conv_result_streamer #(
    parameter int  OUT   = 3,
    parameter int  PIX_W = conv_pkg::PIX_W,
    parameter int  IDX_W = (OUT * OUT > 1) ? $clog2(OUT * OUT) : 1,
    localparam int RC_W  = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [OUT*OUT*PIX_W-1:0] result,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [PIX_W-1:0]         m_data,
    output logic [RC_W-1:0]          m_row,
    output logic [RC_W-1:0]          m_col,
    output logic                     m_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_drop,
    output logic [1:0]               dbg_state
);

    import conv_pkg::*;

    localparam int               NPIX     = OUT * OUT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [RC_W-1:0]  LAST_COL = RC_W'(OUT - 1);

    state_t                   r_state, w_nxt_state;
    logic [IDX_W-1:0]         r_idx, w_nxt_idx, w_idx_inc, w_rd_idx;
    logic [RC_W-1:0]          r_row, r_col, w_nxt_row, w_nxt_col;
    logic                     r_m_valid, w_nxt_valid;
    logic                     r_m_last, w_nxt_last;
    logic                     r_frame_drop, w_nxt_drop;
    logic [PIX_W-1:0]         r_m_data, w_nxt_data, w_buf_pix;
    logic [NPIX*PIX_W-1:0]    r_buf;
    logic [PIX_W-1:0]         w_pix [NPIX];
    logic                     w_done_rise, w_capture, w_accept;

    function automatic logic [PIX_W-1:0] fmt_pix(input logic [PIX_W-1:0] pix);
`ifdef CONV_STREAM_SAT8_EN
        return {{(PIX_W-8){1'b0}}, sat8(pix[15:0])};
`else
        return pix;
`endif
    endfunction

    conv_rise_detect u_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (done),
        .o_rise  (w_done_rise)
    );

    for (genvar g = 0; g < NPIX; g++) begin : g_pix
        assign w_pix[g] = r_buf[g*PIX_W +: PIX_W];
    end

    // The pixel after the current one is prefetched so the output register loads it on acceptance.
    assign w_idx_inc = r_idx + 1'b1;
    assign w_rd_idx  = (r_idx == LAST_IDX) ? '0 : w_idx_inc;
    assign w_buf_pix = w_pix[w_rd_idx];
    assign w_accept  = r_m_valid & m_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_row   = r_row;
        w_nxt_col   = r_col;
        w_nxt_valid = r_m_valid;
        w_nxt_last  = r_m_last;
        w_nxt_data  = r_m_data;
        w_nxt_drop  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_done_rise) begin
                    w_capture   = 1'b1;
                    w_nxt_state = STREAM;
                    w_nxt_idx   = '0;
                    w_nxt_row   = '0;
                    w_nxt_col   = '0;
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = (LAST_IDX == '0);
                    w_nxt_data  = fmt_pix(result[PIX_W-1:0]);
                end
            end
            STREAM: begin
                w_nxt_drop = w_done_rise;
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_nxt_state = DONE;
                        w_nxt_idx   = '0;
                        w_nxt_row   = '0;
                        w_nxt_col   = '0;
                        w_nxt_valid = 1'b0;
                        w_nxt_last  = 1'b0;
                        w_nxt_data  = '0;
                    end else begin
                        w_nxt_idx  = w_idx_inc;
                        w_nxt_data = fmt_pix(w_buf_pix);
                        w_nxt_last = (w_idx_inc == LAST_IDX);
                        if (r_col == LAST_COL) begin
                            w_nxt_col = '0;
                            w_nxt_row = r_row + 1'b1;
                        end else begin
                            w_nxt_col = r_col + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                w_nxt_drop  = w_done_rise;
                w_nxt_state = IDLE;
                w_nxt_idx   = '0;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_data     <= '0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_row        <= w_nxt_row;
            r_col        <= w_nxt_col;
            r_m_valid    <= w_nxt_valid;
            r_m_last     <= w_nxt_last;
            r_m_data     <= w_nxt_data;
            r_frame_drop <= w_nxt_drop;
        end
    end

    // Frame contents are don't-care until the first capture, so the buffer carries no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= result;
        end
    end

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_row      = r_row;
    assign m_col      = r_col;
    assign m_last     = r_m_last;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE);
    assign frame_drop = r_frame_drop;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: transaction-level frame model, random ready/done/result stimulus.
// Build with +define+CONV_STREAM_SAT8_EN to check the saturating output variant.
module tb_conv_result_streamer;

  localparam int OUT   = 3;
  localparam int PIX_W = 16;
  localparam int NPIX  = OUT * OUT;
  localparam int RC_W  = 2;
  localparam int EXP_W = 1 + 2 * RC_W + PIX_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  done = 1'b0;
  logic                  m_ready = 1'b0;
  logic [NPIX*PIX_W-1:0] result = '0;
  logic                  m_valid, m_last, busy, frame_done, frame_drop;
  logic [PIX_W-1:0]      m_data;
  logic [RC_W-1:0]       m_row, m_col;
  logic [1:0]            dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: one entry per expected beat, {last, row, col, data}
  logic [EXP_W-1:0] exp_q[$];
  logic             fd_now = 1'b0;
  logic             drop_now = 1'b0;
  logic             prev_done = 1'b0;
  logic             m_rise, m_busy, m_next_fd;
  logic [EXP_W-1:0] m_head;
  int               beats_acc = 0;
  int               n_fd_obs = 0;
  int               n_drop_obs = 0;

  int ready_mode = 0;
  int rdy_phase = 0;
  int img[25];
  int flt[9];
  int b0, fd0, dr0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv_result_streamer #(.OUT(OUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .result     (result),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_col      (m_col),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_drop (frame_drop),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PIX_W-1:0] exp_pix(input logic [PIX_W-1:0] p);
`ifdef CONV_STREAM_SAT8_EN
    return (p > 16'd255) ? 16'h00FF : p;
`else
    return p;
`endif
  endfunction

  // model of one capture: every pixel of the current result, row-major
  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back({(i == NPIX - 1), RC_W'(i / OUT), RC_W'(i % OUT),
                       exp_pix(result[i*PIX_W +: PIX_W])});
    end
  endtask

  // 5x5 image convolved with a 3x3 filter, valid region, packed like the conv core
  task automatic conv_fill();
    for (int r = 0; r < OUT; r++) begin
      for (int c = 0; c < OUT; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += img[(r + i) * 5 + c + j] * flt[i * 3 + j];
        result[(r * OUT + c) * PIX_W +: PIX_W] = 16'(s);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      tick(1);
      if (exp_q.size() == 0 && !fd_now) break;
    end
    if (k == 300) check("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int target);
    int k;
    for (k = 0; k < 300 && beats_acc < target; k++) tick(1);
    if (beats_acc < target) check("beat_timeout", 32'(beats_acc), 32'(target));
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 10 && !m_valid; k++) @(negedge clk);
    if (!m_valid) check("valid_timeout", 32'(m_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_row"}, 32'(m_row), 32'd0);
    check({tag, "_col"}, 32'(m_col), 32'd0);
    check({tag, "_last"}, 32'(m_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_fdrop"}, 32'(frame_drop), 32'd0);
  endtask

  // consumer ready: 0 = always, 1 = pattern 1,0,0,..., 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / reference model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_all_zero("rst");
        check("rst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        fd_now = 1'b0;
        drop_now = 1'b0;
        prev_done = 1'b0;
      end else begin
        check("frame_done", 32'(frame_done), 32'(fd_now));
        check("frame_drop", 32'(frame_drop), 32'(drop_now));
        check("busy", 32'(busy), 32'((exp_q.size() > 0) || fd_now));
        check("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          m_head = exp_q[0];
          check("beat_data", 32'(m_data), 32'(m_head[PIX_W-1:0]));
          check("beat_col", 32'(m_col), 32'(m_head[PIX_W+RC_W-1:PIX_W]));
          check("beat_row", 32'(m_row), 32'(m_head[PIX_W+2*RC_W-1:PIX_W+RC_W]));
          check("beat_last", 32'(m_last), 32'(m_head[EXP_W-1]));
        end else begin
          check("idle_last", 32'(m_last), 32'd0);
        end
        if (frame_done) n_fd_obs++;
        if (frame_drop) n_drop_obs++;
        // advance the model across the coming clock edge
        m_rise = done & ~prev_done;
        prev_done = done;
        m_busy = (exp_q.size() > 0) || fd_now;
        m_next_fd = 1'b0;
        if (exp_q.size() > 0 && m_ready) begin
          if (exp_q.size() == 1) m_next_fd = 1'b1;
          void'(exp_q.pop_front());
          beats_acc++;
        end
        drop_now = m_rise & m_busy;
        if (m_rise && !m_busy) push_frame();
        fd_now = m_next_fd;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 25; i++) img[i] = i + 1;
    for (int i = 0; i < 9; i++) flt[i] = 1;
    conv_fill();
    tick(3);
    rst = 1'b1;
    tick(2);

    // nominal frame, consumer always ready
    ready_mode = 0;
    b0 = beats_acc;
    fd0 = n_fd_obs;
    done = 1'b1;
    wait_idle();
    check("nom_beats", 32'(beats_acc - b0), 32'd9);
    check("nom_frames", 32'(n_fd_obs - fd0), 32'd1);
    check("nom_busy_after", 32'(busy), 32'd0);

    // backpressure; result changes after capture must not leak into the frame
    done = 1'b0;
    tick(1);
    ready_mode = 1;
    b0 = beats_acc;
    done = 1'b1;
    tick(2);
    for (int p = 0; p < NPIX; p++) result[p*PIX_W +: PIX_W] = 16'($urandom_range(0, 999));
    wait_idle();
    check("bp_beats", 32'(beats_acc - b0), 32'd9);

    // done re-rises during beat 4 of a frame
    ready_mode = 0;
    done = 1'b0;
    conv_fill();
    tick(1);
    b0 = beats_acc;
    fd0 = n_fd_obs;
    dr0 = n_drop_obs;
    done = 1'b1;
    wait_beats(b0 + 3);
    done = 1'b0;
    tick(1);
    done = 1'b1;
    result = ~result;
    tick(1);
    wait_idle();
    check("drop_count", 32'(n_drop_obs - dr0), 32'd1);
    check("drop_beats", 32'(beats_acc - b0), 32'd9);
    check("drop_frames", 32'(n_fd_obs - fd0), 32'd1);

    // done held high: no retrigger
    b0 = beats_acc;
    fd0 = n_fd_obs;
    tick(20);
    check("level_frames", 32'(n_fd_obs - fd0), 32'd0);
    check("level_beats", 32'(beats_acc - b0), 32'd0);

    // asynchronous reset mid-stream
    done = 1'b0;
    conv_fill();
    tick(1);
    b0 = beats_acc;
    done = 1'b1;
    wait_beats(b0 + 5);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    fd0 = n_fd_obs;
    tick(3);
    done = 1'b0;
    rst = 1'b1;
    tick(2);
    check("rst_no_fdone", 32'(n_fd_obs - fd0), 32'd0);
    done = 1'b1;
    wait_valid();
    check("restart_data", 32'(m_data), 32'd63);
    check("restart_row", 32'(m_row), 32'd0);
    check("restart_col", 32'(m_col), 32'd0);
    wait_idle();

    // large values: all-fives filter
    done = 1'b0;
    for (int i = 0; i < 9; i++) flt[i] = 5;
    conv_fill();
    tick(1);
    done = 1'b1;
    wait_valid();
`ifdef CONV_STREAM_SAT8_EN
    check("sat_first", 32'(m_data), 32'h00FF);
`else
    check("sat_first", 32'(m_data), 32'd315);
`endif
    wait_idle();

    // random ready, done toggling and result churn
    ready_mode = 2;
    repeat (800) begin
      tick(1);
      if ($urandom_range(0, 7) == 0) done = ~done;
      if ($urandom_range(0, 3) == 0)
        for (int p = 0; p < NPIX; p++) result[p*PIX_W +: PIX_W] = 16'($urandom_range(0, 700));
    end
    done = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
